cpu_mw: RTL and testbench

- Parametrised successor of the 8-bit accumulator CPU. Same A/B/PC/IR/CCR programming model and opcode map.
- Generalised data and address widths.
- Adds a ready-based memory handshake, so wait-state memory is tolerated, plus a HALT instruction with a halted status output.
- Top-level CPU instance in the system. Connects directly to the memory model or bus.

---
 rtl/cpu_mw_pkg.sv | 81 ++++++++
 rtl/cpu_mw_alu.sv | 66 ++++++
 rtl/cpu_mw.sv | 251 +++++++++++++++++++++++++
 tb/tb_cpu_mw.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mw_pkg.sv
// Shared definitions for the cpu_mw accumulator CPU.
// Holds the opcode map, FSM state encoding, ALU select codes, CCR bit
// indices and the branch-condition helper used by the control path.
package cpu_mw_pkg;

    // Load / store (immediate and direct)
    localparam logic [7:0] OP_LDA_IMM = 8'h86;
    localparam logic [7:0] OP_LDA_DIR = 8'h87;
    localparam logic [7:0] OP_LDB_IMM = 8'h88;
    localparam logic [7:0] OP_LDB_DIR = 8'h89;
    localparam logic [7:0] OP_STA_DIR = 8'h96;
    localparam logic [7:0] OP_STB_DIR = 8'h97;

    // Inherent ALU operations
    localparam logic [7:0] OP_ADD_AB  = 8'h42;
    localparam logic [7:0] OP_SUB_AB  = 8'h43;
    localparam logic [7:0] OP_AND_AB  = 8'h44;
    localparam logic [7:0] OP_OR_AB   = 8'h45;
    localparam logic [7:0] OP_INCA    = 8'h46;
    localparam logic [7:0] OP_INCB    = 8'h47;
    localparam logic [7:0] OP_DECA    = 8'h48;
    localparam logic [7:0] OP_DECB    = 8'h49;

    // Branches
    localparam logic [7:0] OP_BRA     = 8'h20;
    localparam logic [7:0] OP_BMI     = 8'h21;
    localparam logic [7:0] OP_BPL     = 8'h22;
    localparam logic [7:0] OP_BEQ     = 8'h23;
    localparam logic [7:0] OP_BNE     = 8'h24;
    localparam logic [7:0] OP_BVS     = 8'h25;
    localparam logic [7:0] OP_BVC     = 8'h26;
    localparam logic [7:0] OP_BCS     = 8'h27;
    localparam logic [7:0] OP_BCC     = 8'h28;

    localparam logic [7:0] OP_HALT    = 8'hFF;

    // CCR bit positions (NZVC)
    localparam int unsigned CCR_N = 3;
    localparam int unsigned CCR_Z = 2;
    localparam int unsigned CCR_V = 1;
    localparam int unsigned CCR_C = 0;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        OPND,
        MEM,
        HLT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_INCA,
        ALU_INCB,
        ALU_DECA,
        ALU_DECB
    } alu_sel_t;

    // Condition evaluation for the branch opcodes; non-branch opcodes never take.
    function automatic logic branch_taken(input logic [7:0] op, input logic [3:0] ccr);
        logic taken;
        taken = 1'b0;
        case (op)
            OP_BRA:  taken = 1'b1;
            OP_BMI:  taken = ccr[CCR_N];
            OP_BPL:  taken = !ccr[CCR_N];
            OP_BEQ:  taken = ccr[CCR_Z];
            OP_BNE:  taken = !ccr[CCR_Z];
            OP_BVS:  taken = ccr[CCR_V];
            OP_BVC:  taken = !ccr[CCR_V];
            OP_BCS:  taken = ccr[CCR_C];
            OP_BCC:  taken = !ccr[CCR_C];
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/cpu_mw_alu.sv
// Combinational ALU for cpu_mw.
// Ports:
//   a, b    operands (DATA_W)
//   sel     operation select (alu_sel_t)
//   result  operation result (DATA_W), modulo 2^DATA_W
//   nzvc    condition flags, bit positions from cpu_mw_pkg
module cpu_mw_alu
    import cpu_mw_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_sel_t          sel,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        nzvc
);

    localparam int unsigned       MSB = DATA_W - 1;
    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic              sub;
    logic              logic_op;
    logic [DATA_W:0]   sum;

    always_comb begin
        x        = a;
        y        = b;
        sub      = 1'b0;
        logic_op = 1'b0;
        result   = '0;
        nzvc     = '0;
        sum      = '0;

        unique case (sel)
            ALU_ADD:  ;
            ALU_SUB:  sub = 1'b1;
            ALU_AND:  logic_op = 1'b1;
            ALU_OR:   logic_op = 1'b1;
            ALU_INCA: y = ONE;
            ALU_INCB: begin x = b; y = ONE; end
            ALU_DECA: begin y = ONE; sub = 1'b1; end
            ALU_DECB: begin x = b; y = ONE; sub = 1'b1; end
            default:  ;
        endcase

        // Zero-extended subtract leaves the borrow (x < y unsigned) in the top bit.
        sum = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});

        if (logic_op) begin
            result      = (sel == ALU_AND) ? (a & b) : (a | b);
            nzvc[CCR_V] = 1'b0;
            nzvc[CCR_C] = 1'b0;
        end else begin
            result      = sum[DATA_W-1:0];
            nzvc[CCR_C] = sum[DATA_W];
            nzvc[CCR_V] = sub ? ((x[MSB] != y[MSB]) && (result[MSB] != x[MSB]))
                              : ((x[MSB] == y[MSB]) && (result[MSB] != x[MSB]));
        end
        nzvc[CCR_N] = result[MSB];
        nzvc[CCR_Z] = (result == '0);
    end

endmodule

// File: rtl/cpu_mw.sv
// Parametrised accumulator CPU with a ready-based memory handshake and HALT.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-low reset
//   address      memory address, valid while mem_req=1
//   to_memory    write data, valid while mem_req=1 and write=1
//   write        1=write access, 0=read access
//   mem_req      access request, held until accepted
//   mem_ready    access completes at an edge with mem_req=1 and mem_ready=1
//   from_memory  read data, sampled at the completing edge
//   halted       CPU is in the HALT state
// All outputs are registered; each access is launched by the state that
// precedes it so a zero-wait access completes one edge after issue.
module cpu_mw
    import cpu_mw_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] to_memory,
    output logic              write,
    output logic              mem_req,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] from_memory,
    output logic              halted
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] opr_q, opr_d;
    logic [3:0]        ccr_q, ccr_d;
    logic              mem_req_q, mem_req_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] to_memory_q, to_memory_d;
    logic              halted_q, halted_d;

    logic [7:0]        opcode;
    logic [ADDR_W-1:0] pc_inc;
    logic              accept;
    alu_sel_t          alu_sel;
    logic [DATA_W-1:0] alu_result;
    logic [3:0]        alu_nzvc;

    assign opcode = ir_q[7:0];
    assign pc_inc = pc_q + ADDR_W'(1);
    assign accept = mem_req_q && mem_ready;

    assign address   = address_q;
    assign to_memory = to_memory_q;
    assign write     = write_q;
    assign mem_req   = mem_req_q;
    assign halted    = halted_q;

    // Loads update N and Z only; V and C are preserved.
    function automatic logic [3:0] ld_flags(input logic [DATA_W-1:0] v, input logic [3:0] ccr);
        logic [3:0] f;
        f        = ccr;
        f[CCR_N] = v[DATA_W-1];
        f[CCR_Z] = (v == '0);
        return f;
    endfunction

    cpu_mw_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (a_q),
        .b      (b_q),
        .sel    (alu_sel),
        .result (alu_result),
        .nzvc   (alu_nzvc)
    );

    // Kept separate from the main next-state block so the ALU is not in a
    // combinational loop through a single process.
    always_comb begin
        alu_sel = ALU_ADD;
        case (opcode)
            OP_SUB_AB: alu_sel = ALU_SUB;
            OP_AND_AB: alu_sel = ALU_AND;
            OP_OR_AB:  alu_sel = ALU_OR;
            OP_INCA:   alu_sel = ALU_INCA;
            OP_INCB:   alu_sel = ALU_INCB;
            OP_DECA:   alu_sel = ALU_DECA;
            OP_DECB:   alu_sel = ALU_DECB;
            default:   alu_sel = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= FETCH;
            pc_q        <= ADDR_W'(RESET_PC);
            a_q         <= '0;
            b_q         <= '0;
            ir_q        <= '0;
            opr_q       <= '0;
            ccr_q       <= '0;
            mem_req_q   <= 1'b0;
            write_q     <= 1'b0;
            address_q   <= '0;
            to_memory_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ir_q        <= ir_d;
            opr_q       <= opr_d;
            ccr_q       <= ccr_d;
            mem_req_q   <= mem_req_d;
            write_q     <= write_d;
            address_q   <= address_d;
            to_memory_q <= to_memory_d;
            halted_q    <= halted_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        a_d         = a_q;
        b_d         = b_q;
        ir_d        = ir_q;
        opr_d       = opr_q;
        ccr_d       = ccr_q;
        mem_req_d   = mem_req_q;
        write_d     = write_q;
        address_d   = address_q;
        to_memory_d = to_memory_q;
        halted_d    = halted_q;

        unique case (state_q)
            FETCH: begin
                if (!mem_req_q) begin
                    // Only after reset: nothing was launched yet.
                    mem_req_d = 1'b1;
                    write_d   = 1'b0;
                    address_d = pc_q;
                end else if (accept) begin
                    ir_d      = from_memory;
                    pc_d      = pc_inc;
                    mem_req_d = 1'b0;
                    state_d   = DECODE;
                end
            end

            DECODE: begin
                // Default path launches the next fetch (or operand read) at PC.
                state_d   = FETCH;
                mem_req_d = 1'b1;
                write_d   = 1'b0;
                address_d = pc_q;
                case (opcode)
                    OP_ADD_AB, OP_SUB_AB, OP_AND_AB, OP_OR_AB, OP_INCA, OP_DECA: begin
                        a_d   = alu_result;
                        ccr_d = alu_nzvc;
                    end
                    OP_INCB, OP_DECB: begin
                        b_d   = alu_result;
                        ccr_d = alu_nzvc;
                    end
                    OP_LDA_IMM, OP_LDB_IMM, OP_LDA_DIR, OP_LDB_DIR, OP_STA_DIR, OP_STB_DIR,
                    OP_BRA, OP_BMI, OP_BPL, OP_BEQ, OP_BNE, OP_BVS, OP_BVC, OP_BCS, OP_BCC: begin
                        state_d = OPND;
                    end
                    OP_HALT: begin
                        state_d   = HLT;
                        mem_req_d = 1'b0;
                        halted_d  = 1'b1;
                    end
                    default: ;  // unknown opcode behaves as NOP
                endcase
            end

            OPND: begin
                if (accept) begin
                    opr_d     = from_memory;
                    pc_d      = pc_inc;
                    state_d   = FETCH;
                    mem_req_d = 1'b1;
                    write_d   = 1'b0;
                    case (opcode)
                        OP_LDA_IMM: begin
                            a_d   = from_memory;
                            ccr_d = ld_flags(from_memory, ccr_q);
                        end
                        OP_LDB_IMM: begin
                            b_d   = from_memory;
                            ccr_d = ld_flags(from_memory, ccr_q);
                        end
                        OP_LDA_DIR, OP_LDB_DIR: state_d = MEM;
                        OP_STA_DIR: begin
                            state_d     = MEM;
                            write_d     = 1'b1;
                            to_memory_d = a_q;
                        end
                        OP_STB_DIR: begin
                            state_d     = MEM;
                            write_d     = 1'b1;
                            to_memory_d = b_q;
                        end
                        default: begin
                            if (branch_taken(opcode, ccr_q)) begin
                                pc_d = from_memory[ADDR_W-1:0];
                            end
                        end
                    endcase
                    address_d = (state_d == MEM) ? from_memory[ADDR_W-1:0] : pc_d;
                end
            end

            MEM: begin
                if (accept) begin
                    if (opcode == OP_LDA_DIR) begin
                        a_d   = from_memory;
                        ccr_d = ld_flags(from_memory, ccr_q);
                    end else if (opcode == OP_LDB_DIR) begin
                        b_d   = from_memory;
                        ccr_d = ld_flags(from_memory, ccr_q);
                    end
                    state_d     = FETCH;
                    mem_req_d   = 1'b1;
                    write_d     = 1'b0;
                    address_d   = pc_q;
                    to_memory_d = '0;
                end
            end

            HLT: begin
                mem_req_d = 1'b0;
                write_d   = 1'b0;
                halted_d  = 1'b1;
            end

            default: begin
                state_d   = FETCH;
                mem_req_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_mw.sv
// Directed bench for cpu_mw: an 8-bit instance with a wait-state memory
// model and a 16-bit/10-bit-address instance with zero-wait memory.
module tb_cpu_mw;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- 8-bit instance ----------------
    logic       reset8 = 1'b0;
    logic [7:0] address8, to_memory8, from_memory8;
    logic       write8, mem_req8, mem_ready8, halted8;

    cpu_mw #(.DATA_W(8), .ADDR_W(8), .RESET_PC(0)) dut8 (
        .clk         (clk),
        .reset       (reset8),
        .address     (address8),
        .to_memory   (to_memory8),
        .write       (write8),
        .mem_req     (mem_req8),
        .mem_ready   (mem_ready8),
        .from_memory (from_memory8),
        .halted      (halted8)
    );

    logic [7:0] mem8 [256];
    logic       ld8_en   = 1'b0;
    logic [7:0] ld8_addr = 8'h00;
    logic [7:0] ld8_data = 8'h00;
    int         wr8_cnt  = 0;
    int         waits8   = 0;
    bit         hold_wr8 = 1'b0;
    int         wcnt8    = 0;
    int         stab_err8 = 0;
    bit         pwait8   = 1'b0;
    logic [7:0] pa8, pd8;
    logic       pw8;
    logic [7:0] prog8 [$];

    assign from_memory8 = mem8[address8];
    assign mem_ready8   = mem_req8 && (wcnt8 >= waits8) && !(hold_wr8 && write8);

    always @(posedge clk) begin
        if (ld8_en) mem8[ld8_addr] <= ld8_data;
        if (reset8 && mem_req8 && mem_ready8 && write8) begin
            mem8[address8] <= to_memory8;
            wr8_cnt        <= wr8_cnt + 1;
        end
        if (!mem_req8 || mem_ready8) wcnt8 <= 0;
        else                         wcnt8 <= wcnt8 + 1;
        // A request left waiting at the previous edge must present the same access now.
        if (pwait8 && reset8 && (address8 !== pa8 || write8 !== pw8 || to_memory8 !== pd8))
            stab_err8 <= stab_err8 + 1;
        pwait8 <= reset8 && mem_req8 && !mem_ready8;
        pa8    <= address8;
        pw8    <= write8;
        pd8    <= to_memory8;
    end

    // ---------------- 16-bit instance ----------------
    logic        reset16 = 1'b0;
    logic [9:0]  address16;
    logic [15:0] to_memory16, from_memory16;
    logic        write16, mem_req16, mem_ready16, halted16;

    cpu_mw #(.DATA_W(16), .ADDR_W(10), .RESET_PC(0)) dut16 (
        .clk         (clk),
        .reset       (reset16),
        .address     (address16),
        .to_memory   (to_memory16),
        .write       (write16),
        .mem_req     (mem_req16),
        .mem_ready   (mem_ready16),
        .from_memory (from_memory16),
        .halted      (halted16)
    );

    logic [15:0] mem16 [1024];
    logic        ld16_en   = 1'b0;
    logic [9:0]  ld16_addr = 10'h000;
    logic [15:0] ld16_data = 16'h0000;
    logic [15:0] prog16 [$];

    assign from_memory16 = mem16[address16];
    assign mem_ready16   = mem_req16;

    always @(posedge clk) begin
        if (ld16_en) mem16[ld16_addr] <= ld16_data;
        if (reset16 && mem_req16 && mem_ready16 && write16) mem16[address16] <= to_memory16;
    end

    // ---------------- helpers ----------------
    task automatic load8(input logic [7:0] base);
        for (int i = 0; i < prog8.size(); i++) begin
            ld8_addr = base + 8'(i);
            ld8_data = prog8[i];
            ld8_en   = 1'b1;
            @(posedge clk); #1;
        end
        ld8_en = 1'b0;
    endtask

    task automatic load16(input logic [9:0] base);
        for (int i = 0; i < prog16.size(); i++) begin
            ld16_addr = base + 10'(i);
            ld16_data = prog16[i];
            ld16_en   = 1'b1;
            @(posedge clk); #1;
        end
        ld16_en = 1'b0;
    endtask

    // Releases reset and counts edges from the one that raises the first request.
    task automatic run8(input int budget, output int cyc, output bit done);
        bit started;
        started = 1'b0;
        cyc     = 0;
        done    = 1'b0;
        reset8  = 1'b1;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk); #1;
            if (started) cyc++;
            if (mem_req8) started = 1'b1;
            if (halted8) done = 1'b1;
        end
    endtask

    task automatic run16(input int budget, output bit done);
        done    = 1'b0;
        reset16 = 1'b1;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk); #1;
            if (halted16) done = 1'b1;
        end
    endtask

    task automatic hold_reset8();
        reset8 = 1'b0;
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        hold_reset8();
        n_checks++; if (mem_req8 !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req got %b want 0", mem_req8); end
        n_checks++; if (write8 !== 1'b0) begin n_fail++; $display("FAIL rst_write got %b want 0", write8); end
        n_checks++; if (address8 !== 8'h00) begin n_fail++; $display("FAIL rst_address got %h want 00", address8); end
        n_checks++; if (to_memory8 !== 8'h00) begin n_fail++; $display("FAIL rst_to_memory got %h want 00", to_memory8); end
        n_checks++; if (halted8 !== 1'b0) begin n_fail++; $display("FAIL rst_halted got %b want 0", halted8); end
        n_checks++; if (dut8.pc_q !== 8'h00) begin n_fail++; $display("FAIL rst_pc got %h want 00", dut8.pc_q); end
        n_checks++; if (dut8.a_q !== 8'h00) begin n_fail++; $display("FAIL rst_a got %h want 00", dut8.a_q); end
        n_checks++; if (dut8.ccr_q !== 4'h0) begin n_fail++; $display("FAIL rst_ccr got %h want 0", dut8.ccr_q); end
    endtask

    task automatic test_add_halt();
        int cyc;
        bit done;
        hold_reset8();
        waits8 = 0;
        prog8 = {8'h86, 8'h7F, 8'h88, 8'h01, 8'h42, 8'hFF};
        load8(8'h00);
        run8(40, cyc, done);
        n_checks++; if (!done) begin n_fail++; $display("FAIL add_halt_timeout got halted=%b want 1", halted8); end
        // LDA_IMM 3 + LDB_IMM 3 + ADD 2 + HALT 2
        n_checks++; if (cyc != 10) begin n_fail++; $display("FAIL add_halt_cycles got %0d want 10", cyc); end
        n_checks++; if (dut8.a_q !== 8'h80) begin n_fail++; $display("FAIL add_a got %h want 80", dut8.a_q); end
        n_checks++; if (dut8.ccr_q !== 4'b1010) begin n_fail++; $display("FAIL add_ccr got %b want 1010", dut8.ccr_q); end
        n_checks++; if (mem_req8 !== 1'b0) begin n_fail++; $display("FAIL halt_mem_req got %b want 0", mem_req8); end
        @(posedge clk); #1;
        n_checks++; if (mem_req8 !== 1'b0 || halted8 !== 1'b1) begin
            n_fail++; $display("FAIL halt_hold got req=%b halted=%b want req=0 halted=1", mem_req8, halted8);
        end
    endtask

    task automatic test_wait_states();
        int cyc;
        bit done;
        int wr0;
        hold_reset8();
        prog8 = {8'h87, 8'hF0, 8'h96, 8'hF1, 8'hFF};
        load8(8'h00);
        prog8 = {8'h5A, 8'h00};
        load8(8'hF0);
        waits8 = 2;
        wr0 = wr8_cnt;
        run8(100, cyc, done);
        n_checks++; if (!done) begin n_fail++; $display("FAIL wait_timeout got halted=%b want 1", halted8); end
        // zero-wait 4+4+2 = 10, plus 2 waits on each of 7 accesses
        n_checks++; if (cyc != 24) begin n_fail++; $display("FAIL wait_cycles got %0d want 24", cyc); end
        n_checks++; if (mem8[8'hF1] !== 8'h5A) begin n_fail++; $display("FAIL wait_store got %h want 5A", mem8[8'hF1]); end
        n_checks++; if (wr8_cnt - wr0 != 1) begin n_fail++; $display("FAIL wait_writes got %0d want 1", wr8_cnt - wr0); end
        n_checks++; if (dut8.a_q !== 8'h5A) begin n_fail++; $display("FAIL wait_a got %h want 5A", dut8.a_q); end
        n_checks++; if (stab_err8 != 0) begin n_fail++; $display("FAIL wait_stable got %0d want 0", stab_err8); end
        waits8 = 0;
    endtask

    task automatic test_branch();
        int cyc;
        bit done;
        // BEQ taken: PC becomes 10, HALT fetched there leaves PC=11.
        hold_reset8();
        prog8 = {8'h86, 8'h00, 8'h23, 8'h10};
        load8(8'h00);
        prog8 = {8'hFF};
        load8(8'h10);
        run8(40, cyc, done);
        n_checks++; if (!done || dut8.pc_q !== 8'h11) begin
            n_fail++; $display("FAIL beq_taken_pc got %h want 11", dut8.pc_q);
        end
        n_checks++; if (dut8.ccr_q !== 4'b0100) begin n_fail++; $display("FAIL beq_ccr got %b want 0100", dut8.ccr_q); end
        // BEQ not taken: falls through to 04, HALT leaves PC=05.
        hold_reset8();
        prog8 = {8'h86, 8'h01, 8'h23, 8'h10, 8'hFF};
        load8(8'h00);
        run8(40, cyc, done);
        n_checks++; if (!done || dut8.pc_q !== 8'h05) begin
            n_fail++; $display("FAIL beq_not_taken_pc got %h want 05", dut8.pc_q);
        end
        // BRA at FE: operand at FF, PC wraps to 00 before the branch loads 02.
        hold_reset8();
        prog8 = {8'h20, 8'hFE, 8'hFF};
        load8(8'h00);
        prog8 = {8'h20, 8'h02};
        load8(8'hFE);
        run8(40, cyc, done);
        n_checks++; if (!done || dut8.pc_q !== 8'h03) begin
            n_fail++; $display("FAIL bra_wrap_pc got %h want 03", dut8.pc_q);
        end
        n_checks++; if (cyc != 8) begin n_fail++; $display("FAIL bra_cycles got %0d want 8", cyc); end
    endtask

    task automatic test_wide();
        bit done;
        // 0x1286 has junk above bit 7 and must still decode as LDA_IMM.
        reset16 = 1'b0;
        @(posedge clk); #1;
        prog16 = {16'h1286, 16'hFFFF, 16'h0046, 16'h00FF};
        load16(10'h000);
        run16(40, done);
        n_checks++; if (!done) begin n_fail++; $display("FAIL wide_timeout got halted=%b want 1", halted16); end
        n_checks++; if (dut16.a_q !== 16'h0000) begin n_fail++; $display("FAIL wide_inca_a got %h want 0000", dut16.a_q); end
        n_checks++; if (dut16.ccr_q !== 4'b0101) begin n_fail++; $display("FAIL wide_inca_ccr got %b want 0101", dut16.ccr_q); end
        // Operand FC20 addresses 0x020 once bits above ADDR_W are dropped.
        reset16 = 1'b0;
        @(posedge clk); #1;
        prog16 = {16'h0089, 16'hFC20, 16'h00FF};
        load16(10'h000);
        prog16 = {16'h8001};
        load16(10'h020);
        run16(40, done);
        n_checks++; if (!done || dut16.b_q !== 16'h8001) begin
            n_fail++; $display("FAIL wide_ldb_mask got %h want 8001", dut16.b_q);
        end
        n_checks++; if (dut16.ccr_q !== 4'b1000) begin n_fail++; $display("FAIL wide_ldb_ccr got %b want 1000", dut16.ccr_q); end
    endtask

    task automatic test_reset_mid_write();
        bit found;
        int wr0;
        hold_reset8();
        prog8 = {8'h86, 8'h33, 8'h96, 8'h40, 8'hFF};
        load8(8'h00);
        prog8 = {8'h00};
        load8(8'h40);
        waits8   = 0;
        hold_wr8 = 1'b1;
        found    = 1'b0;
        reset8   = 1'b1;
        for (int i = 0; i < 30 && !found; i++) begin
            @(posedge clk); #1;
            if (mem_req8 && write8) found = 1'b1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL midwr_reach got write=%b want 1", write8); end
        n_checks++; if (address8 !== 8'h40 || to_memory8 !== 8'h33) begin
            n_fail++; $display("FAIL midwr_access got %h/%h want 40/33", address8, to_memory8);
        end
        @(posedge clk); #1;
        wr0 = wr8_cnt;
        hold_reset8();
        n_checks++; if (mem_req8 !== 1'b0 || write8 !== 1'b0) begin
            n_fail++; $display("FAIL midwr_req got req=%b wr=%b want 0/0", mem_req8, write8);
        end
        n_checks++; if (address8 !== 8'h00 || to_memory8 !== 8'h00) begin
            n_fail++; $display("FAIL midwr_bus got %h/%h want 00/00", address8, to_memory8);
        end
        n_checks++; if (dut8.pc_q !== 8'h00 || dut8.a_q !== 8'h00) begin
            n_fail++; $display("FAIL midwr_regs got pc=%h a=%h want 00/00", dut8.pc_q, dut8.a_q);
        end
        n_checks++; if (wr8_cnt != wr0 || mem8[8'h40] !== 8'h00) begin
            n_fail++; $display("FAIL midwr_no_write got cnt+%0d mem=%h want 0/00", wr8_cnt - wr0, mem8[8'h40]);
        end
        hold_wr8 = 1'b0;
    endtask

    task automatic test_nop();
        int cyc;
        bit done;
        hold_reset8();
        prog8 = {8'h88, 8'h3C, 8'h86, 8'hC3, 8'h55, 8'hFF};
        load8(8'h00);
        run8(40, cyc, done);
        n_checks++; if (!done || dut8.pc_q !== 8'h06) begin
            n_fail++; $display("FAIL nop_pc got %h want 06", dut8.pc_q);
        end
        // LDB 3 + LDA 3 + NOP 2 + HALT 2
        n_checks++; if (cyc != 10) begin n_fail++; $display("FAIL nop_cycles got %0d want 10", cyc); end
        n_checks++; if (dut8.a_q !== 8'hC3 || dut8.b_q !== 8'h3C) begin
            n_fail++; $display("FAIL nop_regs got a=%h b=%h want C3/3C", dut8.a_q, dut8.b_q);
        end
        n_checks++; if (dut8.ccr_q !== 4'b1000) begin n_fail++; $display("FAIL nop_ccr got %b want 1000", dut8.ccr_q); end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_add_halt();
        test_wait_states();
        test_branch();
        test_wide();
        test_reset_mid_write();
        test_nop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
